// File: rtl/demux2_deserializer.sv
// Receive side of the 2-bit two-channel link: splits the interleaved A/B symbol
// stream and packs each channel MSB-first into words behind a valid/ready register.
module demux2_deserializer #(
  parameter int unsigned SYMS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          din,
  input  logic                din_valid,
  input  logic                frame_sync,
  output logic [2*SYMS-1:0]   out_a,
  output logic                out_a_valid,
  input  logic                out_a_ready,
  output logic [2*SYMS-1:0]   out_b,
  output logic                out_b_valid,
  input  logic                out_b_ready,
  output logic                overrun_a,
  output logic                overrun_b,
  output logic                slot
);

  localparam int unsigned W  = 2 * SYMS;
  localparam int unsigned IW = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam logic [IW-1:0] LAST = IW'(SYMS - 1);

  typedef enum logic {SLOT_A = 1'b0, SLOT_B = 1'b1} slot_e;

  slot_e         r_slot, w_slot_nxt, w_eff_slot;
  logic [IW-1:0] r_idx, w_idx_nxt, w_eff_idx;
  logic [W-1:0]  r_sh_a, r_sh_b, w_sh_a_nxt, w_sh_b_nxt, w_base_a, w_base_b;
  logic [W-1:0]  r_out_a, r_out_b, w_out_a_nxt, w_out_b_nxt;
  logic          r_va, r_vb, w_va_nxt, w_vb_nxt;
  logic          r_ovr_a, r_ovr_b, w_ovr_a_nxt, w_ovr_b_nxt;
  logic          w_done_a, w_done_b;

  // A sync symbol is treated as A/idx0 arriving on freshly cleared shift registers.
  always_comb begin
    w_eff_slot = frame_sync ? SLOT_A : r_slot;
    w_eff_idx  = frame_sync ? '0 : r_idx;
    w_base_a   = frame_sync ? '0 : r_sh_a;
    w_base_b   = frame_sync ? '0 : r_sh_b;
    w_slot_nxt = r_slot;
    w_idx_nxt  = r_idx;
    w_sh_a_nxt = r_sh_a;
    w_sh_b_nxt = r_sh_b;
    w_done_a   = 1'b0;
    w_done_b   = 1'b0;
    if (din_valid) begin
      w_sh_a_nxt = w_base_a;
      w_sh_b_nxt = w_base_b;
      if (w_eff_slot == SLOT_A) begin
        w_sh_a_nxt = {w_base_a[W-3:0], din};
        w_done_a   = (w_eff_idx == LAST);
        w_idx_nxt  = w_eff_idx;
        w_slot_nxt = SLOT_B;
      end else begin
        w_sh_b_nxt = {w_base_b[W-3:0], din};
        w_done_b   = (w_eff_idx == LAST);
        w_idx_nxt  = (w_eff_idx == LAST) ? '0 : w_eff_idx + IW'(1);
        w_slot_nxt = SLOT_A;
      end
    end
  end

  always_comb begin
    w_out_a_nxt = r_out_a;
    w_va_nxt    = r_va;
    w_ovr_a_nxt = r_ovr_a;
    if (w_done_a) begin
      if (!r_va || out_a_ready) begin
        w_out_a_nxt = w_sh_a_nxt;
        w_va_nxt    = 1'b1;
      end else begin
        w_ovr_a_nxt = 1'b1;
      end
    end else if (r_va && out_a_ready) begin
      w_va_nxt = 1'b0;
    end
  end

  always_comb begin
    w_out_b_nxt = r_out_b;
    w_vb_nxt    = r_vb;
    w_ovr_b_nxt = r_ovr_b;
    if (w_done_b) begin
      if (!r_vb || out_b_ready) begin
        w_out_b_nxt = w_sh_b_nxt;
        w_vb_nxt    = 1'b1;
      end else begin
        w_ovr_b_nxt = 1'b1;
      end
    end else if (r_vb && out_b_ready) begin
      w_vb_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot  <= SLOT_A;
      r_idx   <= '0;
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_out_a <= '0;
      r_out_b <= '0;
      r_va    <= 1'b0;
      r_vb    <= 1'b0;
      r_ovr_a <= 1'b0;
      r_ovr_b <= 1'b0;
    end else begin
      r_slot  <= w_slot_nxt;
      r_idx   <= w_idx_nxt;
      r_sh_a  <= w_sh_a_nxt;
      r_sh_b  <= w_sh_b_nxt;
      r_out_a <= w_out_a_nxt;
      r_out_b <= w_out_b_nxt;
      r_va    <= w_va_nxt;
      r_vb    <= w_vb_nxt;
      r_ovr_a <= w_ovr_a_nxt;
      r_ovr_b <= w_ovr_b_nxt;
    end
  end

  assign out_a       = r_out_a;
  assign out_b       = r_out_b;
  assign out_a_valid = r_va;
  assign out_b_valid = r_vb;
  assign overrun_a   = r_ovr_a;
  assign overrun_b   = r_ovr_b;
  assign slot        = r_slot;

endmodule

// File: doc/demux2_deserializer.md
Name: demux2_deserializer

Overview:
- Receive end of the team's 2-bit two-channel multiplexed link. The transmit side alternates 2-bit symbols from channel A and channel B onto one shared 2-bit lane.
- This block splits the interleaved symbol stream back into channel A and channel B.
- It packs each channel's symbols into words and presents each word on its own output register with a valid/ready handshake.
- It sits between the lane input pins and the per-channel consumers.

Parameters:
- SYMS, 4, symbols per output word; word width W = 2*SYMS bits; SYMS must be at least 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  2  lane symbol.
- din_valid  input  1  din carries a symbol this cycle.
- frame_sync  input  1  qualified by din_valid; marks the symbol as channel A, symbol index 0.
- out_a  output  W  channel A word.
- out_a_valid  output  1  out_a holds an unconsumed word.
- out_a_ready  input  1  consumer takes out_a this cycle.
- out_b  output  W  channel B word.
- out_b_valid  output  1  out_b holds an unconsumed word.
- out_b_ready  input  1  consumer takes out_b this cycle.
- overrun_a  output  1  sticky: a completed channel A word was dropped.
- overrun_b  output  1  sticky: a completed channel B word was dropped.
- slot  output  1  channel the next symbol belongs to (0=A, 1=B).

Behaviour:
- Reset (synchronous, active-high, takes priority over everything, including mid-word and mid-handshake):
  - out_a, out_b, the shift registers and the symbol index go to 0.
  - out_a_valid, out_b_valid, overrun_a, overrun_b and slot go to 0.
  - Partial words are discarded.
- Symbol acceptance: every cycle with din_valid=1 consumes one symbol. There is no back-pressure on the lane. Cycles with din_valid=0 change no symbol state.
- Slot rules:
  - Accepted symbol with slot=0 goes to channel A; with slot=1 it goes to channel B.
  - slot toggles on every accepted symbol.
  - The symbol index idx (0..SYMS-1) increments after each channel B symbol and wraps to 0 after SYMS-1.
- Frame sync (frame_sync=1 with din_valid=1):
  - The symbol is forced to channel A, idx 0, whatever the current slot/idx.
  - Both partial shift registers restart; previously accumulated partial symbols are discarded.
  - Completed words already in out_a/out_b are unaffected.
  - After this symbol, slot=1.
  - frame_sync with din_valid=0 is ignored.
- Packing:
  - Symbols pack MSB-first: idx 0 lands in bits [W-1:W-2], idx SYMS-1 in bits [1:0].
- Word completion (channel A at idx SYMS-1, slot 0; channel B at idx SYMS-1, slot 1):
  - The full word transfers to the channel output register at the clock edge that accepts its last symbol.
  - outX_valid=1 from the next cycle, so latency is 1 cycle from the last symbol.
- Handshake:
  - A word is consumed on a cycle with outX_valid=1 and outX_ready=1; valid drops next cycle unless a new word loads.
  - outX and outX_valid stay stable while valid=1 and ready=0.
  - ready while valid=0 has no effect.
- Load rules at completion:
  - Register empty, or consumed in the same cycle: the new word loads and valid is 1 next cycle. Back-to-back words give no bubble.
  - Register full and not consumed: the new word is dropped, the held word is preserved, and overrunX is set to 1.
  - overrunX stays set until rst.
- Channels are independent: A stalling never affects B acceptance, and vice versa.
- slot reflects the registered state and is directly observable for lane alignment checks.

Test Plan:
- Basic split:
  - Stimulus: rst, then frame_sync on the first of 8 consecutive valid symbols 3,0,2,1,1,3,0,2 (A,B alternating), out_*_ready=1.
  - Required response:
    - out_a=8'b11_10_01_00 (0xE4) with out_a_valid one cycle after symbol 7.
    - out_b=8'b00_01_11_10 (0x1E) with out_b_valid one cycle after symbol 8.
    - Each valid lasts one cycle.
- Gapped input:
  - Stimulus: same stream with din_valid=0 inserted between every symbol.
  - Required response: identical words; slot holds during gaps.
- Back-pressure and overrun:
  - Stimulus: out_a_ready=0 across two full frames, then ready=1.
  - Required response:
    - The first A word (0xE4) is held stable.
    - The second A word is dropped and overrun_a=1.
    - Channel B words flow normally with overrun_b=0.
- Consume-and-load same cycle:
  - Stimulus: out_a_ready asserted exactly on the cycle the next A word completes.
  - Required response: the old word is consumed, the new word is valid next cycle, and overrun_a stays 0.
- Mid-frame resync:
  - Stimulus: 3 symbols, then frame_sync on the 4th, then 8 valid symbols.
  - Required response:
    - The partial data is discarded.
    - The words equal those of the 8 symbols after the sync.
    - slot=1 on the cycle after the sync symbol.
- Reset mid-operation:
  - Stimulus: rst asserted while out_b_valid=1 and overrun_a=1, idx=2.
  - Required response: next cycle all outputs are 0 and a following frame decodes as in the basic split test.
